button_conditioner: RTL

Parametrised multi-channel input conditioner that replaces the per-button debouncer instances in the game top level. It converts raw, bouncing push-button lines into clean levels, single-cycle press and release events, and an auto-repeat strobe for held buttons. The game FSM consumes the strobes directly, without its own edge detection. One instance serves all buttons, with one channel per button: Left, Right, Up, Down, Center.

---
 rtl/button_conditioner.sv | 130 +++++++++++++
 1 files changed

// File: rtl/button_conditioner.sv
// Multi-channel push-button conditioner: synchroniser, debouncer, press/release
// events and auto-repeat strobes, one fully independent lane per button.
module button_conditioner #(
    parameter int CHANNELS        = 5,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_DELAY    = 64,
    parameter int REPEAT_PERIOD   = 16
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic [CHANNELS-1:0] Signal,
    output logic [CHANNELS-1:0] Level,
    output logic [CHANNELS-1:0] Pressed,
    output logic [CHANNELS-1:0] Released,
    output logic [CHANNELS-1:0] Repeat,
    output logic                AnyPressed
);

    localparam int CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int HOLD_W   = $clog2(HOLD_MAX + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] DELAY_LAST  = HOLD_W'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
    localparam logic [HOLD_W-1:0] PERIOD_LAST = HOLD_W'(REPEAT_PERIOD - 1);

    // Per-channel repeat FSM: waiting for a press, counting the initial delay,
    // or strobing periodically while the button stays down.
    typedef enum logic [1:0] {
        HOLD_IDLE     = 2'd0,
        HOLD_DELAY    = 2'd1,
        HOLD_PERIODIC = 2'd2
    } holdState_t;

    logic [CHANNELS-1:0] riseNow;

    for (genvar i = 0; i < CHANNELS; i++) begin : gChannel
        logic [SYNC_STAGES-1:0] syncQ;
        logic [CNT_W-1:0]       debCnt;
        logic                   levelQ;
        logic                   pressedQ;
        logic                   releasedQ;
        logic                   repeatQ;
        logic                   mismatch;
        logic                   toggle;
        logic                   rise;
        logic                   fall;
        logic                   fireRepeat;
        holdState_t             holdState;
        holdState_t             holdStateNext;
        logic [HOLD_W-1:0]      holdCnt;
        logic [HOLD_W-1:0]      holdCntNext;

        assign mismatch = syncQ[SYNC_STAGES-1] ^ levelQ;
        assign toggle   = mismatch && (debCnt == CNT_LAST);
        assign rise     = toggle && !levelQ;
        assign fall     = toggle && levelQ;

        // Synchroniser, debounce counter and the registered event outputs.
        always_ff @(posedge Clock or posedge Reset) begin
            if (Reset) begin
                syncQ     <= '0;
                debCnt    <= '0;
                levelQ    <= 1'b0;
                pressedQ  <= 1'b0;
                releasedQ <= 1'b0;
                repeatQ   <= 1'b0;
            end else begin
                syncQ     <= {syncQ[SYNC_STAGES-2:0], Signal[i]};
                debCnt    <= (!mismatch || toggle) ? '0 : debCnt + CNT_W'(1);
                levelQ    <= levelQ ^ toggle;
                pressedQ  <= rise;
                releasedQ <= fall;
                repeatQ   <= fireRepeat;
            end
        end

        always_ff @(posedge Clock or posedge Reset) begin
            if (Reset) begin
                holdState <= HOLD_IDLE;
                holdCnt   <= '0;
            end else begin
                holdState <= holdStateNext;
                holdCnt   <= holdCntNext;
            end
        end

        always_comb begin
            holdStateNext = holdState;
            holdCntNext   = '0;
            case (holdState)
                HOLD_IDLE: begin
                    if (rise && (REPEAT_DELAY > 0)) holdStateNext = HOLD_DELAY;
                end
                HOLD_DELAY: begin
                    if (fall)                         holdStateNext = HOLD_IDLE;
                    else if (holdCnt == DELAY_LAST)   holdStateNext = HOLD_PERIODIC;
                    else                              holdCntNext   = holdCnt + HOLD_W'(1);
                end
                HOLD_PERIODIC: begin
                    // Counter wraps to zero on every strobe; it never saturates.
                    if (fall)                         holdStateNext = HOLD_IDLE;
                    else if (holdCnt != PERIOD_LAST)  holdCntNext   = holdCnt + HOLD_W'(1);
                end
                default: holdStateNext = HOLD_IDLE;
            endcase
        end

        // A release landing on a repeat slot suppresses that repeat.
        always_comb begin
            fireRepeat = rise;
            if (!fall) begin
                if ((holdState == HOLD_DELAY) && (holdCnt == DELAY_LAST))     fireRepeat = 1'b1;
                if ((holdState == HOLD_PERIODIC) && (holdCnt == PERIOD_LAST)) fireRepeat = 1'b1;
            end
        end

        assign riseNow[i]  = rise;
        assign Level[i]    = levelQ;
        assign Pressed[i]  = pressedQ;
        assign Released[i] = releasedQ;
        assign Repeat[i]   = repeatQ;
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) AnyPressed <= 1'b0;
        else       AnyPressed <= |riseNow;
    end

endmodule
